// File: rtl/mul_ctrl_if.sv
// Handshake and strobe bundle between the multiply controller and its datapath/requester.
// The controller takes the slave modport; the requester/datapath side takes master.
interface mul_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic             eqz;
  logic             ack;
  logic             ldA;
  logic             ldB;
  logic             ldP;
  logic             decB;
  logic             clrP;
  logic             done;
  logic             busy;
  logic             err;
  logic [WIDTH-1:0] iter_cnt;

  modport master (
    output start, abort, in_valid, eqz, ack,
    input  in_ready, ldA, ldB, ldP, decB, clrP, done, busy, err, iter_cnt
  );

  modport slave (
    input  start, abort, in_valid, eqz, ack,
    output in_ready, ldA, ldB, ldP, decB, clrP, done, busy, err, iter_cnt
  );
endinterface

// File: rtl/mul_ctrl.sv
// Shift-free repeated-add multiply controller: loads A and B, adds A into P while B != 0,
// with an iteration guard that flags err if B never reaches zero.
module mul_ctrl #(
  parameter int unsigned          WIDTH    = 16,
  parameter logic [WIDTH-1:0]     MAX_ITER = '1
) (
  input logic       clk,
  input logic       rst,
  mul_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LD_A, LD_B, ADD, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] iter_q, iter_d;
  logic             err_q, err_d;

  logic in_ready, ldA, ldB, ldP, decB, clrP, done, busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      iter_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    err_d    = err_q;
    in_ready = 1'b0;
    ldA      = 1'b0;
    ldB      = 1'b0;
    ldP      = 1'b0;
    decB     = 1'b0;
    clrP     = 1'b0;
    done     = (state_q == DONE);
    busy     = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (bus.start) state_d = LD_A;
      end
      LD_A: begin
        in_ready = 1'b1;
        ldA      = bus.in_valid;
        if (bus.in_valid) state_d = LD_B;
      end
      LD_B: begin
        in_ready = 1'b1;
        ldB      = bus.in_valid;
        clrP     = bus.in_valid;
        if (bus.in_valid) begin
          state_d = ADD;
          iter_d  = '0;
          err_d   = 1'b0;
        end
      end
      ADD: begin
        // An unknown eqz falls through to the not-zero path; the guard bounds it.
        if (bus.eqz == 1'b1) begin
          state_d = DONE;
          err_d   = 1'b0;
        end else if (iter_q == MAX_ITER) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          ldP    = 1'b1;
          decB   = 1'b1;
          iter_d = iter_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides whatever the state decode chose, but leaves iter_cnt as it was.
    if (bus.abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      err_d    = 1'b0;
      iter_d   = iter_q;
      in_ready = 1'b0;
      ldA      = 1'b0;
      ldB      = 1'b0;
      ldP      = 1'b0;
      decB     = 1'b0;
      clrP     = 1'b0;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.ldA      = ldA;
  assign bus.ldB      = ldB;
  assign bus.ldP      = ldP;
  assign bus.decB     = decB;
  assign bus.clrP     = clrP;
  assign bus.done     = done;
  assign bus.busy     = busy;
  assign bus.err      = err_q;
  assign bus.iter_cnt = iter_q;

endmodule
